// File: rtl/ysyx_22041071_wb_queue.sv
// rtl/ysyx_22041071_wb_queue.sv - registered write-back FIFO with commit, retire count and ebreak halt
// Optional commit trace: define YSYX_22041071_WB_TRACE_EN.
module ysyx_22041071_wb_queue #(
  parameter int XLEN  = 64,
  parameter int AW    = 64,
  parameter int IW    = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_pc,
  input  logic [IW-1:0]   in_ins,
  input  logic            in_wen,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_pc,
  output logic [IW-1:0]   out_ins,
  output logic            rf_wen,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic [63:0]     retire_cnt,
  output logic            halt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [IW-1:0] EBREAK = IW'(32'h0010_0073);

  logic [AW-1:0]   mem_pc   [DEPTH];
  logic [IW-1:0]   mem_ins  [DEPTH];
  logic            mem_wen  [DEPTH];
  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Full-pass: a full queue still accepts when the head leaves this cycle.
  assign in_ready  = reset && !halt && ((count < FULL) || out_ready);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_pc  = out_valid ? mem_pc[rd_ptr]   : '0;
  assign out_ins = out_valid ? mem_ins[rd_ptr]  : '0;
  assign rf_rd   = out_valid ? mem_rd[rd_ptr]   : '0;
  assign rf_data = out_valid ? mem_data[rd_ptr] : '0;
  assign rf_wen  = pop && mem_wen[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= in_pc;
      mem_ins[wr_ptr]  <= in_ins;
      mem_wen[wr_ptr]  <= in_wen && (in_rd != 5'd0);
      mem_rd[wr_ptr]   <= in_rd;
      mem_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      retire_cnt <= '0;
      halt       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        retire_cnt <= retire_cnt + 64'd1;
        if (mem_ins[rd_ptr] == EBREAK) halt <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef YSYX_22041071_WB_TRACE_EN
  always @(posedge clk) begin
    if (reset && pop) begin
      $display("[wb] pc=%h rd=%0d wen=%0b data=%h",
               mem_pc[rd_ptr], mem_rd[rd_ptr], mem_wen[rd_ptr], mem_data[rd_ptr]);
      if (!halt && mem_ins[rd_ptr] == EBREAK)
        $display("[wb] ebreak committed at pc=%h, halting", mem_pc[rd_ptr]);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22041071_wb_queue.sv
// tb/tb_ysyx_22041071_wb_queue.sv - directed bench for ysyx_22041071_wb_queue
module tb_ysyx_22041071_wb_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [31:0] in_ins = '0;
  logic        in_wen = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_ins;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [63:0] rf_data;
  logic [63:0] retire_cnt;
  logic        halt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_22041071_wb_queue #(.XLEN(64), .AW(64), .IW(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ins(in_ins),
    .in_wen(in_wen), .in_rd(in_rd), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data),
    .retire_cnt(retire_cnt), .halt(halt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic wen, input logic [4:0] rd, input logic [63:0] data);
    in_valid = v; in_pc = pc; in_ins = ins; in_wen = wen; in_rd = rd; in_data = data;
  endtask

  initial begin
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_halt", halt, 0);
    check("rst_retire", retire_cnt, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_rf_data", rf_data, 0);
    tick();
    reset = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1);

    // single instruction
    out_ready = 1'b1;
    drive(1, 64'h8000_0000, 32'h0050_0293, 1, 5'd5, 64'h1234);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("single_valid", out_valid, 1);
    check("single_rf_wen", rf_wen, 1);
    check("single_rf_rd", rf_rd, 5);
    check("single_rf_data", rf_data, 64'h1234);
    check("single_pc", out_pc, 64'h8000_0000);
    check("single_retire_pre", retire_cnt, 0);
    tick();
    check("single_retire", retire_cnt, 1);
    check("single_empty", out_valid, 0);

    // x0 write is suppressed but still retires
    drive(1, 64'h8000_0004, 32'h0000_0013, 1, 5'd0, 64'hFFFF);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("x0_valid", out_valid, 1);
    check("x0_rf_wen", rf_wen, 0);
    tick();
    check("x0_retire", retire_cnt, 2);

    // backpressure with DEPTH=2
    out_ready = 1'b0;
    drive(1, 64'h0, 32'h13, 1, 5'd1, 64'h10);
    tick();
    drive(1, 64'h4, 32'h13, 1, 5'd2, 64'h20);
    tick();
    drive(1, 64'h8, 32'h13, 1, 5'd3, 64'h30);
    #1;
    check("bp_full_refuse", in_ready, 0);
    check("bp_head_pc", out_pc, 64'h0);
    tick();
    check("bp_still_refuse", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp_pass_ready", in_ready, 1);
    check("bp_pop0_data", rf_data, 64'h10);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("bp_pop1_pc", out_pc, 64'h4);
    check("bp_pop1_rd", rf_rd, 2);
    tick();
    check("bp_pop2_pc", out_pc, 64'h8);
    check("bp_pop2_data", rf_data, 64'h30);
    tick();
    check("bp_drained", out_valid, 0);
    check("bp_retire", retire_cnt, 5);

    // full queue streaming with simultaneous push/pop
    out_ready = 1'b0;
    drive(1, 64'h100, 32'h13, 1, 5'd7, 64'h100);
    tick();
    drive(1, 64'h104, 32'h13, 1, 5'd7, 64'h104);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 64'h108 + 64'(4 * i), 32'h13, 1, 5'd7, 64'h108 + 64'(4 * i));
      #1;
      if (in_ready !== 1'b1 || out_pc !== 64'h100 + 64'(4 * i)) begin
        check("stream_ready", in_ready, 1);
        check("stream_pc", out_pc, 64'h100 + 64'(4 * i));
      end else begin
        checks++;
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1'b0;
    #1;
    check("stream_still_full", in_ready, 0);
    check("stream_head", out_pc, 64'h128);
    out_ready = 1'b1;
    tick();
    check("stream_tail", out_pc, 64'h12c);
    tick();
    check("stream_empty", out_valid, 0);
    check("stream_retire", retire_cnt, 17);

    // halt on ebreak commit
    out_ready = 1'b0;
    drive(1, 64'h200, 32'h0010_0073, 0, 5'd0, 64'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    #1;
    check("halt_pre", halt, 0);
    check("halt_ebreak_ins", out_ins, 32'h0010_0073);
    tick();
    check("halt_set", halt, 1);
    check("halt_in_ready", in_ready, 0);
    check("halt_retire", retire_cnt, 18);
    drive(1, 64'h204, 32'h0010_8093, 1, 5'd1, 64'h1);
    #1;
    check("halt_refuse_addi", in_ready, 0);
    tick();
    tick();
    check("halt_no_addi", out_valid, 0);
    check("halt_sticky", halt, 1);
    drive(0, 0, 0, 0, 0, 0);

    // reset mid-stream
    reset = 1'b0;
    #1;
    check("rst2_halt", halt, 0);
    tick();
    reset = 1'b1;
    drive(1, 64'h300, 32'h13, 1, 5'd4, 64'h44);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("pre_rst_retire", retire_cnt, 1);
    out_ready = 1'b0;
    drive(1, 64'h304, 32'h13, 1, 5'd4, 64'h1);
    tick();
    drive(1, 64'h308, 32'h13, 1, 5'd4, 64'h2);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("pre_rst_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_retire", retire_cnt, 0);
    check("mid_rst_halt", halt, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_pc", out_pc, 0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1, 64'h400, 32'h13, 1, 5'd9, 64'h99);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("post_rst_pc", out_pc, 64'h400);
    check("post_rst_rf_wen", rf_wen, 1);
    tick();
    check("post_rst_retire", retire_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
